// File: rtl/trace_request_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : trace_request_queue_if
// Description : Handshake bundle between the trace front end, the timestamped
//               request queue and the DDR5 controller scheduler. The queue
//               itself binds to the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface trace_request_queue_if #(
    parameter int MEM_ADDR_WIDTH = 36,
    parameter int CPU_CLK_WIDTH  = 32,
    parameter int CPU_CORE_WIDTH = 4,
    parameter int MEM_OPN_WIDTH  = 3,
    parameter int QUEUE_DEPTH    = 16
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    // Control
    logic                      skip_en;

    // Enqueue side
    logic                      in_valid;
    logic                      in_ready;
    logic [CPU_CLK_WIDTH-1:0]  in_time;
    logic [CPU_CORE_WIDTH-1:0] in_core;
    logic [MEM_OPN_WIDTH-1:0]  in_opn;
    logic [MEM_ADDR_WIDTH-1:0] in_addr;

    // Issue side
    logic                      out_valid;
    logic                      out_ready;
    logic [CPU_CLK_WIDTH-1:0]  out_time;
    logic [CPU_CORE_WIDTH-1:0] out_core;
    logic [MEM_OPN_WIDTH-1:0]  out_opn;
    logic [MEM_ADDR_WIDTH-1:0] out_addr;

    // Status
    logic [CPU_CLK_WIDTH-1:0]  cycle;
    logic [CNT_W-1:0]          count;
    logic                      err_opn;
    logic [15:0]               err_cnt;

    modport slave (
        input  skip_en,
        input  in_valid, in_time, in_core, in_opn, in_addr,
        output in_ready,
        output out_valid, out_time, out_core, out_opn, out_addr,
        input  out_ready,
        output cycle, count, err_opn, err_cnt
    );

    modport master (
        output skip_en,
        output in_valid, in_time, in_core, in_opn, in_addr,
        input  in_ready,
        input  out_valid, out_time, out_core, out_opn, out_addr,
        output out_ready,
        input  cycle, count, err_opn, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/trace_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : trace_request_queue
// Description : In-order FIFO of parsed trace entries. The head entry is
//               released only once the internal CPU cycle counter reaches its
//               timestamp; optional skip mode jumps the counter forward to the
//               head timestamp instead of idling.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_request_queue #(
    parameter int MEM_ADDR_WIDTH = 36,
    parameter int CPU_CLK_WIDTH  = 32,
    parameter int CPU_CORE_WIDTH = 4,
    parameter int MEM_OPN_WIDTH  = 3,
    parameter int QUEUE_DEPTH    = 16
) (
    input  wire                    clk,
    input  wire                    rst,
    trace_request_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    localparam logic [MEM_OPN_WIDTH-1:0] c_OPN_MAX = MEM_OPN_WIDTH'(2);
    localparam logic [CNT_W-1:0]         c_FULL    = CNT_W'(QUEUE_DEPTH);
    localparam logic [15:0]              c_ERR_MAX = 16'hFFFF;

    // Entry storage (data path only, no reset needed)
    logic [CPU_CLK_WIDTH-1:0]  r_mem_time [QUEUE_DEPTH];
    logic [CPU_CORE_WIDTH-1:0] r_mem_core [QUEUE_DEPTH];
    logic [MEM_OPN_WIDTH-1:0]  r_mem_opn  [QUEUE_DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr [QUEUE_DEPTH];

    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;
    logic [CPU_CLK_WIDTH-1:0]  r_cycle;
    logic                      r_err_opn;
    logic [15:0]               r_err_cnt;

    logic [CPU_CLK_WIDTH-1:0]  w_head_time;
    logic                      w_in_ready;
    logic                      w_out_valid;
    logic                      w_push;
    logic                      w_store;
    logic                      w_drop;
    logic                      w_pop;
    logic                      w_not_empty;

    // Readiness is decoded purely from registered state so neither side sees
    // a combinational path from the other.
    assign w_head_time = r_mem_time[r_rd_ptr];
    assign w_not_empty = (r_count != '0);
    assign w_in_ready  = (r_count != c_FULL);
    assign w_out_valid = w_not_empty && (w_head_time <= r_cycle);

    // Invalid operation codes still complete the handshake but are discarded.
    assign w_push  = bus.in_valid && w_in_ready;
    assign w_store = w_push && (bus.in_opn <= c_OPN_MAX);
    assign w_drop  = w_push && (bus.in_opn >  c_OPN_MAX);
    assign w_pop   = w_out_valid && bus.out_ready;

    // Write accepted entries at the tail; the head slot is never overwritten
    // while occupied because a full queue refuses input.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem_time[r_wr_ptr] <= bus.in_time;
            r_mem_core[r_wr_ptr] <= bus.in_core;
            r_mem_opn[r_wr_ptr]  <= bus.in_opn;
            r_mem_addr[r_wr_ptr] <= bus.in_addr;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_store && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_store && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // CPU cycle counter: saturates, optionally skips idle time to the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
        end else if (r_cycle == '1) begin
            r_cycle <= r_cycle;
        end else if (bus.skip_en && w_not_empty && (w_head_time > r_cycle)) begin
            r_cycle <= w_head_time;
        end else begin
            r_cycle <= r_cycle + CPU_CLK_WIDTH'(1);
        end
    end

    // Dropped-entry reporting: one-cycle pulse plus saturating tally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_opn <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err_opn <= w_drop;
            if (w_drop && (r_err_cnt != c_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_time  = w_head_time;
    assign bus.out_core  = r_mem_core[r_rd_ptr];
    assign bus.out_opn   = r_mem_opn[r_rd_ptr];
    assign bus.out_addr  = r_mem_addr[r_rd_ptr];
    assign bus.cycle     = r_cycle;
    assign bus.count     = r_count;
    assign bus.err_opn   = r_err_opn;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trace_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_request_queue
// Description : Self-checking bench for trace_request_queue. A queue-based
//               reference model predicts every visible output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_request_queue;
    localparam int AW    = 36;
    localparam int TW    = 32;
    localparam int CW    = 4;
    localparam int OW    = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    trace_request_queue_if #(
        .MEM_ADDR_WIDTH(AW), .CPU_CLK_WIDTH(TW), .CPU_CORE_WIDTH(CW),
        .MEM_OPN_WIDTH(OW), .QUEUE_DEPTH(DEPTH)
    ) bus ();

    trace_request_queue #(
        .MEM_ADDR_WIDTH(AW), .CPU_CLK_WIDTH(TW), .CPU_CORE_WIDTH(CW),
        .MEM_OPN_WIDTH(OW), .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [TW-1:0] t;
        logic [CW-1:0] c;
        logic [OW-1:0] o;
        logic [AW-1:0] a;
    } ent_t;

    ent_t          mq[$];
    logic [TW-1:0] m_cycle;
    logic          m_err_opn;
    logic [15:0]   m_err_cnt;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cycle   = '0;
        m_err_opn = 1'b0;
        m_err_cnt = '0;
    endtask

    task automatic drive(input bit v, input logic [TW-1:0] t, input logic [CW-1:0] c,
                         input logic [OW-1:0] o, input logic [AW-1:0] a);
        bus.in_valid = v;
        bus.in_time  = t;
        bus.in_core  = c;
        bus.in_opn   = o;
        bus.in_addr  = a;
    endtask

    // Compare all outputs with the model, then advance model and DUT one edge.
    task automatic tick();
        bit            exp_ready;
        bit            exp_valid;
        bit            do_push;
        bit            do_pop;
        logic [TW-1:0] nxt;
        ent_t          e;
        #1;
        exp_ready = (mq.size() < DEPTH);
        exp_valid = (mq.size() > 0) && (mq[0].t <= m_cycle);
        chk("in_ready",  64'(bus.in_ready),  64'(exp_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        chk("count",     64'(bus.count),     64'(mq.size()));
        chk("cycle",     64'(bus.cycle),     64'(m_cycle));
        chk("err_opn",   64'(bus.err_opn),   64'(m_err_opn));
        chk("err_cnt",   64'(bus.err_cnt),   64'(m_err_cnt));
        if (mq.size() > 0) begin
            chk("out_time", 64'(bus.out_time), 64'(mq[0].t));
            chk("out_core", 64'(bus.out_core), 64'(mq[0].c));
            chk("out_opn",  64'(bus.out_opn),  64'(mq[0].o));
            chk("out_addr", 64'(bus.out_addr), 64'(mq[0].a));
        end
        do_push = bus.in_valid && exp_ready;
        do_pop  = exp_valid && bus.out_ready;
        if (m_cycle == '1)
            nxt = m_cycle;
        else if (bus.skip_en && mq.size() > 0 && mq[0].t > m_cycle)
            nxt = mq[0].t;
        else
            nxt = m_cycle + 1;
        if (do_pop) void'(mq.pop_front());
        m_err_opn = do_push && (bus.in_opn > 2);
        if (do_push && bus.in_opn <= 2) begin
            e.t = bus.in_time; e.c = bus.in_core; e.o = bus.in_opn; e.a = bus.in_addr;
            mq.push_back(e);
        end
        if (m_err_opn && m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 1;
        m_cycle = nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        logic [TW-1:0] t;
        logic [OW-1:0] o;

        bus.skip_en   = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, '0, '0, '0, '0);
        model_reset();

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_cycle",     64'(bus.cycle),     64'd0);
        chk("rst_count",     64'(bus.count),     64'd0);
        chk("rst_err_cnt",   64'(bus.err_cnt),   64'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("cycle_after_rst", 64'(bus.cycle), 64'd1);

        // Single entry released exactly at its timestamp
        bus.out_ready = 1'b1;
        drive(1, 32'd5, 4'd3, 3'd0, 36'h1_2345_6780);
        tick();
        drive(0, '0, '0, '0, '0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                chk("issue_cycle", 64'(bus.cycle), 64'd5);
                chk("issue_addr",  64'(bus.out_addr), 64'h1_2345_6780);
            end
            tick();
        end
        chk("issue_seen",   64'(seen),      64'd1);
        chk("single_count", 64'(bus.count), 64'd0);

        // Fill to full with a fifth entry held back
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1, '0, CW'(k), OW'(k % 3), {4'(k), 32'($urandom)});
            tick();
        end
        chk("full_count", 64'(bus.count),    64'd4);
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("full_ready_reopen", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
        tick();
        chk("fifth_accepted", 64'(bus.count), 64'd4);
        // Eight more through pointer wrap
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1, '0, CW'($urandom), OW'($urandom_range(0, 2)), AW'({$urandom, $urandom}));
            tick();
        end
        drive(0, '0, '0, '0, '0);
        for (int k = 0; k < 8; k++) tick();
        chk("drain_count", 64'(bus.count), 64'd0);

        // Invalid operation code is dropped and reported
        drive(1, '0, 4'd1, 3'd5, 36'h0_0000_00AA);
        tick();
        drive(0, '0, '0, '0, '0);
        chk("err_pulse_hi", 64'(bus.err_opn), 64'd1);
        chk("err_cnt_one",  64'(bus.err_cnt), 64'd1);
        tick();
        chk("err_pulse_lo", 64'(bus.err_opn), 64'd0);

        // Skip mode jumps straight to the head timestamp
        #1 rst = 1'b1;
        #1 model_reset();
        @(negedge clk) rst = 1'b0;
        tick();
        tick();
        bus.skip_en   = 1'b1;
        bus.out_ready = 1'b0;
        drive(1, 32'd1000, 4'd7, 3'd1, 36'h0_DEAD_BEEF);
        tick();
        drive(0, '0, '0, '0, '0);
        tick();
        chk("skip_cycle", 64'(bus.cycle),     64'd1000);
        chk("skip_valid", 64'(bus.out_valid), 64'd1);
        tick();
        chk("skip_hold_inc", 64'(bus.cycle), 64'd1001);
        bus.out_ready = 1'b1;
        tick();
        bus.skip_en = 1'b0;
        tick();

        // Reset mid-stream flushes without a clock edge
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1, m_cycle + 5000, CW'(k), 3'd2, AW'(k));
            tick();
        end
        drive(0, '0, '0, '0, '0);
        chk("pre_flush_count", 64'(bus.count), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("flush_count", 64'(bus.count),     64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_cycle", 64'(bus.cycle),     64'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("flush_hold_cycle", 64'(bus.cycle), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Randomized traffic, including out-of-order timestamps and skipping
        for (int i = 0; i < 400; i++) begin
            t = ($urandom_range(0, 4) == 0 && m_cycle > 3) ? m_cycle - 3
                                                           : m_cycle + $urandom_range(0, 8);
            o = ($urandom_range(0, 4) == 0) ? OW'($urandom_range(3, 7)) : OW'($urandom_range(0, 2));
            drive($urandom_range(0, 1) == 1, t, CW'($urandom), o, AW'({$urandom, $urandom}));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.skip_en   = ($urandom_range(0, 3) == 0);
            tick();
        end
        drive(0, '0, '0, '0, '0);
        bus.out_ready = 1'b1;
        bus.skip_en   = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk("final_count", 64'(bus.count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
